// File: rtl/piano_note_scheduler.sv
// piano_note_scheduler: PS/2 make/break sequencer with a last-pressed note stack.
// Optional space-bar sustain pedal is built when SCHED_SUSTAIN_EN is defined.
module piano_note_scheduler #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MIN_HOLD  = 500000,
  parameter logic [5:0]  STOP_CODE = 6'h3F
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] scan_code,
  input  logic       scan_code_ready,
  output logic [7:0] map_code,
  output logic       map_ready,
  input  logic [5:0] map_note,
  output logic [5:0] note,
  output logic       note_valid,
  output logic       drop
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam int TW = $clog2(MIN_HOLD + 1);
  localparam logic [TW-1:0] HOLD_LD = TW'(MIN_HOLD - 1);
  localparam logic [7:0] BRK_B = 8'hF0;
  localparam logic [7:0] EXT_B = 8'hE0;
`ifdef SCHED_SUSTAIN_EN
  localparam logic [7:0] SPC_B = 8'h29;
`endif

  typedef enum logic [2:0] {
    IDLE, BRK, EXT, EXT_BRK, LOOKUP
  } state_t;

  state_t          state_q, state_d;
  logic            brk_q, brk_d;
  logic [7:0]      code_q, code_d;
  logic [5:0]      stk_q [DEPTH];
  logic [5:0]      stk_d [DEPTH];
  logic [DEPTH-1:0] rel_q, rel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [5:0]      note_q, note_d;
  logic            valid_q, valid_d;
  logic            drop_q;
  logic            sus_q, sus_d;

  logic            hit;
  logic [IW-1:0]   hit_idx;
  logic [DEPTH-1:0] keep;
  logic [DEPTH-1:0] rel_m;
  logic            do_push;
  logic [5:0]      c_stk [DEPTH];
  logic [DEPTH-1:0] c_rel;
  logic [CW-1:0]   c_cnt;
  logic            chg;

  always_comb begin
    state_d = state_q;
    brk_d   = brk_q;
    code_d  = code_q;
    sus_d   = sus_q;
    unique case (state_q)
      IDLE: if (scan_code_ready) begin
        if (scan_code == BRK_B) state_d = BRK;
        else if (scan_code == EXT_B) state_d = EXT;
`ifdef SCHED_SUSTAIN_EN
        else if (scan_code == SPC_B) sus_d = 1'b1;
`endif
        else begin
          code_d  = scan_code;
          brk_d   = 1'b0;
          state_d = LOOKUP;
        end
      end
      BRK: if (scan_code_ready) begin
        if (scan_code == EXT_B) state_d = EXT_BRK;
        else if (scan_code == BRK_B) state_d = BRK;
`ifdef SCHED_SUSTAIN_EN
        else if (scan_code == SPC_B) begin
          sus_d   = 1'b0;
          state_d = IDLE;
        end
`endif
        else begin
          code_d  = scan_code;
          brk_d   = 1'b1;
          state_d = LOOKUP;
        end
      end
      EXT: if (scan_code_ready) begin
        state_d = (scan_code == BRK_B) ? EXT_BRK : IDLE;
      end
      EXT_BRK: if (scan_code_ready) state_d = IDLE;
      LOOKUP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && CW'(i) < cnt_q && stk_q[i] == map_note) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
    rel_m   = rel_q;
    keep    = '1;
    do_push = 1'b0;
    if (state_q == LOOKUP && map_note != STOP_CODE) begin
      if (brk_q) begin
        if (hit) begin
`ifdef SCHED_SUSTAIN_EN
          if (sus_q) rel_m[hit_idx] = 1'b1;
          else keep[hit_idx] = 1'b0;
`else
          keep[hit_idx] = 1'b0;
`endif
        end
      end else if (!hit) begin
        do_push = 1'b1;
      end
`ifdef SCHED_SUSTAIN_EN
      else if (rel_q[hit_idx]) begin
        keep[hit_idx] = 1'b0;
        do_push       = 1'b1;
      end
`endif
    end
`ifdef SCHED_SUSTAIN_EN
    if (sus_q && !sus_d) keep = ~rel_q;
`endif
    // Compact surviving entries toward the top, then optionally push.
    c_stk = stk_q;
    c_rel = rel_m;
    c_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < cnt_q && keep[i]) begin
        c_stk[IW'(c_cnt)] = stk_q[i];
        c_rel[IW'(c_cnt)] = rel_m[i];
        c_cnt = c_cnt + 1'b1;
      end
    end
    stk_d = c_stk;
    rel_d = c_rel;
    cnt_d = c_cnt;
    if (do_push) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        stk_d[i] = c_stk[i-1];
        rel_d[i] = c_rel[i-1];
      end
      stk_d[0] = map_note;
      rel_d[0] = 1'b0;
      cnt_d = (c_cnt == CW'(DEPTH)) ? c_cnt : c_cnt + 1'b1;
    end
  end

  always_comb begin
    chg     = (cnt_d != '0) && (cnt_q == '0 || stk_d[0] != stk_q[0]);
    note_d  = note_q;
    valid_d = valid_q;
    tmr_d   = (tmr_q != '0) ? tmr_q - 1'b1 : '0;
    if (cnt_d != '0) begin
      note_d  = stk_d[0];
      valid_d = 1'b1;
      if (chg) tmr_d = HOLD_LD;
    end else if (tmr_q == '0) begin
      note_d  = STOP_CODE;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      brk_q   <= 1'b0;
      code_q  <= 8'h00;
      stk_q   <= '{default: '0};
      rel_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      note_q  <= STOP_CODE;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      brk_q   <= brk_d;
      code_q  <= code_d;
      stk_q   <= stk_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      note_q  <= note_d;
      valid_q <= valid_d;
      drop_q  <= (state_q == LOOKUP) && scan_code_ready;
    end
  end

`ifdef SCHED_SUSTAIN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sus_q <= 1'b0;
    else sus_q <= sus_d;
  end
`else
  assign sus_q = 1'b0;
`endif

  assign map_code   = code_q;
  assign map_ready  = (state_q == LOOKUP);
  assign note       = note_q;
  assign note_valid = valid_q;
  assign drop       = drop_q;

endmodule

// File: tb/tb_piano_note_scheduler.sv
// tb_piano_note_scheduler: directed scan-code sequences with a note-change
// scoreboard and a behavioural keyboard_to_piano mapper.
module tb_piano_note_scheduler;

  localparam int DEPTH = 4;
  localparam int HOLD  = 40;
  localparam logic [5:0] STOP = 6'h3F;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] scan_code = 8'h00;
  logic       scan_code_ready = 1'b0;
  logic [7:0] map_code;
  logic       map_ready;
  logic [5:0] map_note;
  logic [5:0] note;
  logic       note_valid;
  logic       drop;

  int n_asrt = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_lk = 0;
  int rise_cyc = 0;
  int fall_cyc = 0;
  int lk0;
  logic [6:0] exp_q [$];
  logic [6:0] prev = {1'b0, 6'h3F};
  logic [6:0] cur;
  logic [6:0] e;

  piano_note_scheduler #(
    .DEPTH(DEPTH), .MIN_HOLD(HOLD), .STOP_CODE(STOP)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .scan_code(scan_code), .scan_code_ready(scan_code_ready),
    .map_code(map_code), .map_ready(map_ready), .map_note(map_note),
    .note(note), .note_valid(note_valid), .drop(drop)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (map_code)
      8'h15:   map_note = 6'h00;
      8'h1D:   map_note = 6'h02;
      8'h24:   map_note = 6'h04;
      8'h2D:   map_note = 6'h05;
      8'h2C:   map_note = 6'h06;
      default: map_note = STOP;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    scan_code = b;
    scan_code_ready = 1'b1;
    @(negedge clk);
    scan_code_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_ev(input logic v, input logic [5:0] n);
    exp_q.push_back({v, n});
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard: every change of {note_valid, note} must match the queue head.
  initial forever begin
    @(negedge clk);
    if (map_ready) n_lk++;
    cur = {note_valid, note};
    if (cur !== prev) begin
      if (cur[6] && !prev[6]) rise_cyc = cyc;
      if (!cur[6] && prev[6]) fall_cyc = cyc;
      n_asrt++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_extra: observed %0h expected no change", cur);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_note", 32'(cur), 32'(e));
      end
      prev = cur;
    end
  end

  initial begin
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_note", 32'(note), 32'(STOP));
    chk("rst_valid", 32'(note_valid), 32'd0);
    chk("rst_map_code", 32'(map_code), 32'd0);
    chk("rst_map_ready", 32'(map_ready), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    expect_ev(1'b1, 6'h00);
    send(8'h15);
    chk("t1_latency_note", 32'(note), 32'h00);
    chk("t1_latency_valid", 32'(note_valid), 32'd1);
    chk("t1_map_code", 32'(map_code), 32'h15);
    expect_ev(1'b0, STOP);
    send(8'hF0);
    send(8'h15);
    chk("t1_held_after_break", 32'(note_valid), 32'd1);
    drain("t1_silence", 200);
    chk("t1_hold_len", 32'(fall_cyc - rise_cyc), 32'(HOLD));

    expect_ev(1'b1, 6'h00);
    send(8'h15);
    expect_ev(1'b1, 6'h02);
    send(8'h1D);
    chk("t2_top_w", 32'(note), 32'h02);
    expect_ev(1'b1, 6'h00);
    send(8'hF0);
    send(8'h1D);
    chk("t2_fallback", 32'(note), 32'h00);
    expect_ev(1'b0, STOP);
    send(8'hF0);
    send(8'h15);
    drain("t2_silence", 200);

    expect_ev(1'b1, 6'h00);
    send(8'h15);
    expect_ev(1'b1, 6'h02);
    send(8'h1D);
    expect_ev(1'b1, 6'h04);
    send(8'h24);
    expect_ev(1'b1, 6'h05);
    send(8'h2D);
    expect_ev(1'b1, 6'h06);
    send(8'h2C);
    chk("t3_top_full", 32'(note), 32'h06);
    send(8'hF0);
    send(8'h15);
    chk("t3_oldest_gone", 32'(note), 32'h06);
    expect_ev(1'b1, 6'h05);
    send(8'hF0);
    send(8'h2C);
    chk("t3_pop_top", 32'(note), 32'h05);
    expect_ev(1'b1, 6'h04);
    send(8'hF0);
    send(8'h2D);
    expect_ev(1'b1, 6'h02);
    send(8'hF0);
    send(8'h24);
    expect_ev(1'b0, STOP);
    send(8'hF0);
    send(8'h1D);
    drain("t3_silence", 200);

    lk0 = n_lk;
    expect_ev(1'b1, 6'h00);
    send(8'h15);
    send(8'h15);
    send(8'h15);
    chk("t4_repeat_lookups", 32'(n_lk - lk0), 32'd3);
    lk0 = n_lk;
    send(8'hE0);
    send(8'h75);
    chk("t4_ext_make_lookups", 32'(n_lk - lk0), 32'd0);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("t4_ext_break_lookups", 32'(n_lk - lk0), 32'd0);
    send(8'h1C);
    chk("t4_unmapped_lookup", 32'(n_lk - lk0), 32'd1);
    chk("t4_note_kept", 32'(note), 32'h00);
    expect_ev(1'b0, STOP);
    send(8'hF0);
    send(8'h15);
    drain("t4_silence", 200);
    chk("t4_no_reload", 32'(fall_cyc - rise_cyc), 32'(HOLD));

    lk0 = n_lk;
    expect_ev(1'b1, 6'h00);
    scan_code = 8'h15;
    scan_code_ready = 1'b1;
    @(negedge clk);
    scan_code = 8'h1D;
    @(negedge clk);
    scan_code_ready = 1'b0;
    chk("t5_drop_pulse", 32'(drop), 32'd1);
    chk("t5_drop_note", 32'(note), 32'h00);
    chk("t5_drop_map_code", 32'(map_code), 32'h15);
    @(negedge clk);
    chk("t5_drop_clear", 32'(drop), 32'd0);
    chk("t5_drop_lookups", 32'(n_lk - lk0), 32'd1);
    send(8'hF0);
    send(8'h15);
    repeat (3) @(negedge clk);
    chk("t5_mid_hold", 32'(note_valid), 32'd1);
    expect_ev(1'b0, STOP);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_note", 32'(note), 32'(STOP));
    chk("t5_rst_valid", 32'(note_valid), 32'd0);
    chk("t5_rst_map_code", 32'(map_code), 32'd0);
    chk("t5_rst_map_ready", 32'(map_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drain("t5_reset_event", 10);

`ifdef SCHED_SUSTAIN_EN
    lk0 = n_lk;
    send(8'h29);
    chk("t6_space_no_lookup", 32'(n_lk - lk0), 32'd0);
    expect_ev(1'b1, 6'h00);
    send(8'h15);
    send(8'hF0);
    send(8'h15);
    repeat (3) @(negedge clk);
    chk("t6_sustained_note", 32'(note), 32'h00);
    chk("t6_sustained_valid", 32'(note_valid), 32'd1);
    expect_ev(1'b0, STOP);
    send(8'hF0);
    send(8'h29);
    drain("t6_pedal_up", 200);
`else
    lk0 = n_lk;
    send(8'h29);
    chk("t6_space_lookup", 32'(n_lk - lk0), 32'd1);
    repeat (5) @(negedge clk);
    chk("t6_space_silent", 32'(note_valid), 32'd0);
    chk("t6_space_note", 32'(note), 32'(STOP));
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
